decode_stage: RTL
=================

Name: decode_stage

Overview:
- Second pipeline stage. Consumes the registered {pc, instruction} word produced by the fetch stage.
- Reads operands from an internal 8x16 register file and detects load-use hazards.
- Drives a registered decoded bundle to execute.
- A flush from branch/jump resolution kills the in-flight word. Stall requests propagate back to PC/fetch.

Parameters:
- ADDR_W, 9, pc width; fetch word is ADDR_W+BLOCK_W = 25 bits.
- BLOCK_W, 16, instruction/data width.
- NREG, 8, register count (3-bit index); r0 hardwired to 0.

Ports:
- rst  in  1  asynchronous, active-low reset.
- clk  in  1  clock.
- inst_in  in  ADDR_W+BLOCK_W  {pc, instr} from fetch; all-zero = bubble.
- flush  in  1  do_branch|do_jump; kill current decode.
- stall_in  in  1  execute cannot accept; hold output register.
- wb_en  in  1  register write enable.
- wb_addr  in  3  write index.
- wb_data  in  BLOCK_W  write data.
- stall_out  out  1  combinational; PC logic must hold pc (fetch re-presents same word).
- d_valid  out  1  bundle valid.
- d_pc  out  ADDR_W  pc of decoded instruction.
- d_op  out  4  opcode.
- d_rd  out  3  destination index.
- d_s_idx, d_t_idx  out  3 each  source indices.
- d_s_val, d_t_val  out  BLOCK_W each  operand values.
- d_imm  out  BLOCK_W  extended immediate.
- d_illegal  out  1  undefined opcode seen (decoded as NOP).

Behaviour:
- Format instr[15:0]: op[15:12], rd[11:9], rs[8:6], rt[5:3], imm6[5:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: R[rd] = R[rs] op R[rt]; s=rs, t=rt.
  - 5 ADDI: s=rs, imm=sext(imm6).
  - 6 LD: R[rd] = M[R[rs]+sext(imm6)]; s=rs.
  - 7 ST: M[R[rs]+sext(imm6)] = R[rd]; s=rs, t=rd.
  - 8 BEQ: s=rs, t=rd, imm=sext(imm6).
  - 9 JMP: imm = zext(instr[11:0]).
  - 10-15: illegal; d_op=0, d_illegal=1, d_valid=1.
- Unused operand index is driven as 0. Unused imm is 0.
- Register file:
  - Written on posedge when wb_en && wb_addr!=0.
  - Reads are combinational with write-through: if wb_en && wb_addr==idx && idx!=0, the value is wb_data.
  - Reading index 0 always returns 0.
- Latency: inst_in at edge N appears decoded on the outputs after edge N+1 (one register stage).
- Bubble: inst_in==0 gives d_valid=0 and all other d_* fields 0.
- Load-use hazard:
  - hz = d_valid && d_op==LD && d_rd!=0 && d_rd matches a used source index of the current inst_in.
  - While hz: stall_out=1, and the next register load is a bubble.
  - Resolves in exactly 1 cycle.
- stall_out = hz | stall_in, forced 0 when flush.
- Priority per edge: reset > flush > stall_in > hz > normal load.
  - flush: output register becomes a bubble regardless of stall_in.
  - stall_in (no flush): all d_* hold. If wb_en && wb_addr!=0 matches held d_s_idx/d_t_idx, the corresponding d_*_val captures wb_data, so held operands never go stale.
- Reset (async, mid-operation allowed): all d_* = 0, d_valid=0, d_illegal=0, all registers = 0. stall_out = 0 while rst low.

Test Plan:
- Reset, then wb r1=0x0005, r2=0x0003, then inst_in={pc=9'd4, 0x1A50} (ADD r5,r1,r2) -> next cycle d_valid=1, d_pc=4, d_op=1, d_rd=5, d_s_val=5, d_t_val=3.
- Write-through: wb_en r3=0x00AA in the same cycle as ADDI r4,r3,-1 (0x58FF) -> d_s_val=0x00AA, d_imm=0xFFFF.
- Load-use: LD r2,0(r1) (0x6440) followed by ADD r3,r2,r1 (0x1688) -> stall_out=1 for exactly one cycle, one bubble out, then ADD decoded with d_s_idx=2.
- Flush and hazard in the same cycle -> stall_out=0, next d_valid=0; stall_in=1 with flush -> still bubble.
- stall_in held 3 cycles on ADD r5,r1,r2 while wb r1=0x0077 -> d_* held, d_s_val becomes 0x0077; write to r0 is ignored and reads return 0.
- Opcode 0xF and an all-zero word -> d_illegal=1/d_op=0 versus d_valid=0. Async rst low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: register file read, load-use hazard detection and
// the registered decoded bundle handed to execute.
module decode_stage #(
  parameter int ADDR_W  = 9,
  parameter int BLOCK_W = 16,
  parameter int NREG    = 8
) (
  input  logic                      rst,
  input  logic                      clk,
  input  logic [ADDR_W+BLOCK_W-1:0] inst_in,
  input  logic                      flush,
  input  logic                      stall_in,
  input  logic                      wb_en,
  input  logic [2:0]                wb_addr,
  input  logic [BLOCK_W-1:0]        wb_data,
  output logic                      stall_out,
  output logic                      d_valid,
  output logic [ADDR_W-1:0]         d_pc,
  output logic [3:0]                d_op,
  output logic [2:0]                d_rd,
  output logic [2:0]                d_s_idx,
  output logic [2:0]                d_t_idx,
  output logic [BLOCK_W-1:0]        d_s_val,
  output logic [BLOCK_W-1:0]        d_t_val,
  output logic [BLOCK_W-1:0]        d_imm,
  output logic                      d_illegal
);

  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;

  typedef struct packed {
    logic               valid;
    logic [ADDR_W-1:0]  pc;
    logic [3:0]         op;
    logic [2:0]         rd;
    logic [2:0]         s_idx;
    logic [2:0]         t_idx;
    logic [BLOCK_W-1:0] s_val;
    logic [BLOCK_W-1:0] t_val;
    logic [BLOCK_W-1:0] imm;
    logic               illegal;
  } bundle_t;

  logic [BLOCK_W-1:0] regs_q [NREG];
  bundle_t            bun_q, bun_d, dec;

  logic [15:0]        ins;
  logic [3:0]         op;
  logic               is_alu, is_addi, is_ld, is_mem_br;
  logic               is_jmp, is_ill;
  logic               wb_hit, hz;

  assign ins       = inst_in[15:0];
  assign op        = ins[15:12];
  assign wb_hit    = wb_en && (wb_addr != 3'd0);
  assign is_alu    = (op >= 4'd1) && (op <= 4'd4);
  assign is_addi   = (op == OP_ADDI);
  assign is_ld     = (op == OP_LD);
  assign is_mem_br = (op == OP_ST) || (op == OP_BEQ);
  assign is_jmp    = (op == OP_JMP);
  assign is_ill    = (op >= 4'd10);

  always_comb begin
    dec       = '0;
    dec.valid = (inst_in != '0);
    if (dec.valid) begin
      dec.pc = inst_in[ADDR_W+BLOCK_W-1:BLOCK_W];
      unique case (1'b1)
        is_alu: begin
          dec.op    = op;
          dec.rd    = ins[11:9];
          dec.s_idx = ins[8:6];
          dec.t_idx = ins[5:3];
        end
        is_addi, is_ld: begin
          dec.op    = op;
          dec.rd    = ins[11:9];
          dec.s_idx = ins[8:6];
          dec.imm   = {{(BLOCK_W-6){ins[5]}}, ins[5:0]};
        end
        is_mem_br: begin
          dec.op    = op;
          dec.s_idx = ins[8:6];
          dec.t_idx = ins[11:9];
          dec.imm   = {{(BLOCK_W-6){ins[5]}}, ins[5:0]};
        end
        is_jmp: begin
          dec.op  = op;
          dec.imm = {{(BLOCK_W-12){1'b0}}, ins[11:0]};
        end
        is_ill: dec.illegal = 1'b1;
        default: dec.op = 4'd0;
      endcase
    end
    // write-through so a same-cycle writeback is never missed
    if (dec.s_idx != 3'd0)
      dec.s_val = (wb_en && wb_addr == dec.s_idx) ?
                  wb_data : regs_q[dec.s_idx];
    if (dec.t_idx != 3'd0)
      dec.t_val = (wb_en && wb_addr == dec.t_idx) ?
                  wb_data : regs_q[dec.t_idx];
  end

  assign hz = bun_q.valid && (bun_q.op == OP_LD) &&
              (bun_q.rd != 3'd0) &&
              ((dec.s_idx == bun_q.rd) ||
               (dec.t_idx == bun_q.rd));

  assign stall_out = rst && !flush && (hz || stall_in);

  always_comb begin
    bun_d = bun_q;
    if (flush) begin
      bun_d = '0;
    end else if (stall_in) begin
      if (wb_hit && wb_addr == bun_q.s_idx) bun_d.s_val = wb_data;
      if (wb_hit && wb_addr == bun_q.t_idx) bun_d.t_val = wb_data;
    end else if (hz) begin
      bun_d = '0;
    end else begin
      bun_d = dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bun_q <= '0;
    end else begin
      bun_q <= bun_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_hit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign d_valid   = bun_q.valid;
  assign d_pc      = bun_q.pc;
  assign d_op      = bun_q.op;
  assign d_rd      = bun_q.rd;
  assign d_s_idx   = bun_q.s_idx;
  assign d_t_idx   = bun_q.t_idx;
  assign d_s_val   = bun_q.s_val;
  assign d_t_val   = bun_q.t_val;
  assign d_imm     = bun_q.imm;
  assign d_illegal = bun_q.illegal;

endmodule
